// File: rtl/udt_server_handshake.sv
// UDT listening-side connection manager: receives a regular-connect request, validates and
// negotiates it, and answers with the handshake response; exports the negotiated parameters.
module udt_server_handshake (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        Req_Listen,
    input  logic        Req_Close,
    output logic        Res_Connect,
    output logic        Res_Close,
    input  logic [31:0] Local_ISN,
    input  logic [31:0] Local_SockID,
    input  logic [31:0] MSSize,
    input  logic [31:0] FlightFlagSize,
    input  logic [63:0] handshake_tdata,
    input  logic [7:0]  handshake_tkeep,
    input  logic        handshake_tvalid,
    output logic        handshake_tready,
    input  logic        handshake_tlast,
    output logic [63:0] rsp_tdata,
    output logic [7:0]  rsp_tkeep,
    output logic        rsp_tvalid,
    input  logic        rsp_tready,
    output logic        rsp_tlast,
    output logic [31:0] udt_state,
    output logic        state_valid,
    input  logic        state_ready,
    output logic [31:0] PeerISN,
    output logic [31:0] PeerSockID,
    output logic [31:0] Max_PktSize,
    output logic [31:0] Max_PayloadSize,
    output logic [31:0] FlowWindowSize,
    output logic [15:0] Drop_Count
);
    typedef enum logic [2:0] {
        S_CLOSED, S_LISTEN, S_RECV, S_CHECK, S_SEND, S_CONNECTED, S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic        conn_q, conn_d;      // stable state to return to: 0 LISTEN, 1 CONNECTED
    logic        close_q, close_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [63:0] rx_q [8];
    logic [63:0] rx_d [8];
    logic        rx_wr;
    logic [31:0] peer_isn_q, peer_isn_d, peer_sid_q, peer_sid_d;
    logic [31:0] mss_q, mss_d, flow_q, flow_d, pkt_q, pkt_d, pay_q, pay_d;
    logic [15:0] drop_q, drop_d;
    logic [1:0]  ustate_q, ustate_d;
    logic        valid_q, valid_d, res_conn_q, res_conn_d, res_close_q, res_close_d;
    logic        hs_fire, beat_bad, check_pass, drop_inc, finish;
    logic [31:0] mss_min;
    logic [63:0] rsp_word;
    logic        unused_bits;

    assign hs_fire  = handshake_tvalid && handshake_tready;
    assign beat_bad = (handshake_tkeep != 8'hFF) || (handshake_tlast != (rx_cnt_q == 3'd7));
    assign check_pass = rx_q[0][63] && (rx_q[0][62:48] == 15'd0) &&
                        (rx_q[2][63:32] == 32'd4) && (rx_q[4][31:0] == 32'd1) &&
                        (rx_q[3][31:0] >= 32'd76) &&
                        (!conn_q || (rx_q[5][63:32] == peer_sid_q));
    assign unused_bits = ^{rx_q[0][47:0], rx_q[1][31:0]};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rx
            assign rx_d[gi] = (rx_wr && (rx_cnt_q == 3'(gi))) ? handshake_tdata : rx_q[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        conn_d      = conn_q;
        close_d     = close_q;
        rx_cnt_d    = rx_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        rx_wr       = 1'b0;
        peer_isn_d  = peer_isn_q;
        peer_sid_d  = peer_sid_q;
        mss_d       = mss_q;
        flow_d      = flow_q;
        pkt_d       = pkt_q;
        pay_d       = pay_q;
        drop_inc    = 1'b0;
        finish      = 1'b0;
        res_conn_d  = 1'b0;
        res_close_d = 1'b0;
        mss_min     = (rx_q[3][31:0] < MSSize) ? rx_q[3][31:0] : MSSize;

        // A close arriving mid-packet is deferred until the packet is finished
        if (Req_Close && (state_q == S_RECV || state_q == S_CHECK ||
                          state_q == S_DISCARD || state_q == S_SEND))
            close_d = 1'b1;

        case (state_q)
            S_CLOSED: begin
                if (Req_Close) begin
                    res_close_d = 1'b1;
                end else if (Req_Listen) begin
                    state_d = S_LISTEN;
                    conn_d  = 1'b0;
                end
            end
            S_LISTEN, S_CONNECTED, S_RECV: begin
                if (Req_Close && state_q != S_RECV) begin
                    state_d     = S_CLOSED;
                    res_close_d = 1'b1;
                end else if (hs_fire) begin
                    if (beat_bad) begin
                        if (handshake_tlast) begin
                            drop_inc = 1'b1;
                            finish   = 1'b1;
                        end else begin
                            state_d = S_DISCARD;
                        end
                    end else begin
                        rx_wr    = 1'b1;
                        rx_cnt_d = rx_cnt_q + 3'd1;
                        state_d  = (rx_cnt_q == 3'd7) ? S_CHECK : S_RECV;
                    end
                end
            end
            S_DISCARD: begin
                if (hs_fire && handshake_tlast) begin
                    drop_inc = 1'b1;
                    finish   = 1'b1;
                end
            end
            S_CHECK: begin
                if (check_pass) begin
                    if (!conn_q) begin
                        peer_isn_d = rx_q[3][63:32];
                        peer_sid_d = rx_q[5][63:32];
                        mss_d      = mss_min;
                        pkt_d      = mss_min - 32'd28;
                        pay_d      = mss_min - 32'd44;
                        flow_d     = (rx_q[4][63:32] < FlightFlagSize) ? rx_q[4][63:32]
                                                                       : FlightFlagSize;
                    end
                    state_d  = S_SEND;
                    tx_cnt_d = 3'd0;
                end else begin
                    drop_inc = 1'b1;
                    finish   = 1'b1;
                end
            end
            S_SEND: begin
                if (rsp_tready) begin
                    tx_cnt_d = tx_cnt_q + 3'd1;
                    if (tx_cnt_q == 3'd7) begin
                        res_conn_d = !conn_q && !close_d;
                        conn_d     = 1'b1;
                        finish     = 1'b1;
                    end
                end
            end
            default: state_d = S_CLOSED;
        endcase

        if (finish) begin
            rx_cnt_d = 3'd0;
            if (close_d) begin
                state_d     = S_CLOSED;
                res_close_d = 1'b1;
                close_d     = 1'b0;
            end else begin
                state_d = conn_d ? S_CONNECTED : S_LISTEN;
            end
        end
        if (state_d == S_CLOSED) close_d = 1'b0;

        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

        ustate_d = ustate_q;
        if (state_d == S_CLOSED)         ustate_d = 2'd0;
        else if (state_d == S_LISTEN)    ustate_d = 2'd1;
        else if (state_d == S_CONNECTED) ustate_d = 2'd2;
        valid_d = (ustate_d != ustate_q) || (valid_q && !state_ready);
    end

    always_comb begin
        rsp_word = 64'd0;
        case (tx_cnt_q)
            3'd0: rsp_word = {32'h8000_0000, 32'd0};
            3'd1: rsp_word = {rx_q[1][63:32], peer_sid_q};
            3'd2: rsp_word = {32'd4, rx_q[2][31:0]};
            3'd3: rsp_word = {Local_ISN, mss_q};
            3'd4: rsp_word = {flow_q, 32'hFFFF_FFFF};
            3'd5: rsp_word = {Local_SockID, rx_q[5][31:0]};
            3'd6: rsp_word = rx_q[6];
            default: rsp_word = rx_q[7];
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q     <= S_CLOSED;
            conn_q      <= 1'b0;
            close_q     <= 1'b0;
            rx_cnt_q    <= 3'd0;
            tx_cnt_q    <= 3'd0;
            peer_isn_q  <= '0;
            peer_sid_q  <= '0;
            mss_q       <= '0;
            flow_q      <= '0;
            pkt_q       <= '0;
            pay_q       <= '0;
            drop_q      <= '0;
            ustate_q    <= 2'd0;
            valid_q     <= 1'b0;
            res_conn_q  <= 1'b0;
            res_close_q <= 1'b0;
            for (int i = 0; i < 8; i++) rx_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            conn_q      <= conn_d;
            close_q     <= close_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            peer_isn_q  <= peer_isn_d;
            peer_sid_q  <= peer_sid_d;
            mss_q       <= mss_d;
            flow_q      <= flow_d;
            pkt_q       <= pkt_d;
            pay_q       <= pay_d;
            drop_q      <= drop_d;
            ustate_q    <= ustate_d;
            valid_q     <= valid_d;
            res_conn_q  <= res_conn_d;
            res_close_q <= res_close_d;
            for (int i = 0; i < 8; i++) rx_q[i] <= rx_d[i];
        end
    end

    assign handshake_tready = (state_q == S_LISTEN) || (state_q == S_RECV) ||
                              (state_q == S_CONNECTED) || (state_q == S_DISCARD);
    assign rsp_tvalid       = (state_q == S_SEND);
    assign rsp_tdata        = rsp_tvalid ? rsp_word : 64'd0;
    assign rsp_tkeep        = {8{rsp_tvalid}};
    assign rsp_tlast        = rsp_tvalid && (tx_cnt_q == 3'd7);
    assign udt_state        = {30'd0, ustate_q};
    assign state_valid      = valid_q;
    assign Res_Connect      = res_conn_q;
    assign Res_Close        = res_close_q;
    assign PeerISN          = peer_isn_q;
    assign PeerSockID       = peer_sid_q;
    assign Max_PktSize      = pkt_q;
    assign Max_PayloadSize  = pay_q;
    assign FlowWindowSize   = flow_q;
    assign Drop_Count       = drop_q;
endmodule

// File: tb/tb_udt_server_handshake.sv
// Bench for udt_server_handshake: directed scenarios plus randomized requests checked against
// a field-level model of the responder's accept/negotiate/respond rules.
`timescale 1ns/1ps
module tb_udt_server_handshake;
    logic        clk = 1'b0;
    logic        core_rst, Req_Listen, Req_Close, Res_Connect, Res_Close;
    logic [31:0] Local_ISN, Local_SockID, MSSize, FlightFlagSize;
    logic [63:0] handshake_tdata;
    logic [7:0]  handshake_tkeep;
    logic        handshake_tvalid, handshake_tready, handshake_tlast;
    logic [63:0] rsp_tdata;
    logic [7:0]  rsp_tkeep;
    logic        rsp_tvalid, rsp_tready, rsp_tlast;
    logic [31:0] udt_state;
    logic        state_valid, state_ready;
    logic [31:0] PeerISN, PeerSockID, Max_PktSize, Max_PayloadSize, FlowWindowSize;
    logic [15:0] Drop_Count;

    always #5 clk = ~clk;

    udt_server_handshake dut (
        .core_clk(clk), .core_rst(core_rst), .Req_Listen(Req_Listen), .Req_Close(Req_Close),
        .Res_Connect(Res_Connect), .Res_Close(Res_Close), .Local_ISN(Local_ISN),
        .Local_SockID(Local_SockID), .MSSize(MSSize), .FlightFlagSize(FlightFlagSize),
        .handshake_tdata(handshake_tdata), .handshake_tkeep(handshake_tkeep),
        .handshake_tvalid(handshake_tvalid), .handshake_tready(handshake_tready),
        .handshake_tlast(handshake_tlast), .rsp_tdata(rsp_tdata), .rsp_tkeep(rsp_tkeep),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tlast(rsp_tlast),
        .udt_state(udt_state), .state_valid(state_valid), .state_ready(state_ready),
        .PeerISN(PeerISN), .PeerSockID(PeerSockID), .Max_PktSize(Max_PktSize),
        .Max_PayloadSize(Max_PayloadSize), .FlowWindowSize(FlowWindowSize),
        .Drop_Count(Drop_Count)
    );

    typedef struct {
        logic [31:0] w0, w1, ts, dst, ver, stype, isn, mss, flight, rtype, sid, cookie;
        logic [31:0] ip0, ip1, ip2, ip3;
    } req_t;

    int total = 0, bad = 0;
    int cyc = 0, n_conn = 0, n_close = 0;
    int last_cyc, tlast_cyc;
    logic [63:0] req_b [8];
    logic [63:0] exp_b [8];
    logic [63:0] got_b [8];
    logic [7:0]  got_keep [8];
    logic        got_last [8];

    // Reference model state
    int          m_state;       // 0 closed, 1 listening, 2 connected
    int          m_drop;
    logic [31:0] m_sid, m_mss, m_flow;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (Res_Connect) n_conn <= n_conn + 1;
        if (Res_Close) n_close <= n_close + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic req_t make_req(input logic [31:0] sid);
        req_t r;
        r.w0 = 32'h8000_0000; r.w1 = 32'd0; r.ts = $urandom; r.dst = 32'd0;
        r.ver = 32'd4; r.stype = $urandom_range(1, 2); r.isn = 32'h1000; r.mss = 32'd1500;
        r.flight = 32'd25600; r.rtype = 32'd1; r.sid = sid; r.cookie = $urandom;
        r.ip0 = $urandom; r.ip1 = $urandom; r.ip2 = $urandom; r.ip3 = $urandom;
        return r;
    endfunction

    task automatic load_req(input req_t r);
        req_b[0] = {r.w0, r.w1};     req_b[1] = {r.ts, r.dst};
        req_b[2] = {r.ver, r.stype}; req_b[3] = {r.isn, r.mss};
        req_b[4] = {r.flight, r.rtype}; req_b[5] = {r.sid, r.cookie};
        req_b[6] = {r.ip0, r.ip1};   req_b[7] = {r.ip2, r.ip3};
    endtask

    function automatic bit m_accepts(input req_t r);
        if (r.w0[31] != 1'b1 || r.w0[30:16] != 15'd0) return 1'b0;
        if (r.ver != 32'd4 || r.rtype != 32'd1 || r.mss < 32'd76) return 1'b0;
        if (m_state == 2 && r.sid != m_sid) return 1'b0;
        return 1'b1;
    endfunction

    // Accepted request: negotiate when listening, then form the expected response
    task automatic m_accept(input req_t r);
        if (m_state == 1) begin
            m_sid  = r.sid;
            m_mss  = (r.mss < MSSize) ? r.mss : MSSize;
            m_flow = (r.flight < FlightFlagSize) ? r.flight : FlightFlagSize;
            m_state = 2;
        end
        exp_b[0] = {32'h8000_0000, 32'd0};
        exp_b[1] = {r.ts, m_sid};
        exp_b[2] = {32'd4, r.stype};
        exp_b[3] = {Local_ISN, m_mss};
        exp_b[4] = {m_flow, 32'hFFFF_FFFF};
        exp_b[5] = {Local_SockID, r.cookie};
        exp_b[6] = {r.ip0, r.ip1};
        exp_b[7] = {r.ip2, r.ip3};
    endtask

    task automatic send_pkt(input int nbeats, input bit with_last, input int bad_keep_at);
        for (int i = 0; i < nbeats; i++) begin
            int w = 0;
            handshake_tdata  = req_b[i];
            handshake_tkeep  = (i == bad_keep_at) ? 8'h0F : 8'hFF;
            handshake_tlast  = with_last && (i == nbeats - 1);
            handshake_tvalid = 1'b1;
            while (!handshake_tready && w < 50) begin tick(); w++; end
            if (w >= 50) chk("tready_wait", handshake_tready, 1);
            last_cyc = cyc;
            tick();
        end
        handshake_tvalid = 1'b0;
        handshake_tlast  = 1'b0;
    endtask

    // mode 0: ready always, 1: ready alternating, 2: ready random
    task automatic collect_rsp(input int mode, input int close_at);
        int n = 0, w = 0;
        bit stalled = 0, close_sent = 0;
        logic [63:0] held = '0;
        tlast_cyc = -1;
        while (n < 8 && w < 300) begin
            Req_Close = (rsp_tvalid && n == close_at && !close_sent);
            if (Req_Close) close_sent = 1;
            case (mode)
                0: rsp_tready = 1'b1;
                1: rsp_tready = (cyc % 2 == 0);
                default: rsp_tready = 1'($urandom_range(0, 1));
            endcase
            if (rsp_tvalid) begin
                if (stalled) chk("rsp_stable", rsp_tdata, held);
                if (rsp_tready) begin
                    got_b[n] = rsp_tdata; got_keep[n] = rsp_tkeep; got_last[n] = rsp_tlast;
                    if (rsp_tlast) tlast_cyc = cyc;
                    n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = rsp_tdata;
                end
            end
            tick();
            w++;
        end
        Req_Close  = 1'b0;
        rsp_tready = 1'b1;
        if (n < 8) chk("rsp_beat_count", n, 8);
    endtask

    task automatic check_rsp(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_data_b%0d", tag, i), got_b[i], exp_b[i]);
            chk($sformatf("%s_keep_b%0d", tag, i), got_keep[i], 8'hFF);
            chk($sformatf("%s_last_b%0d", tag, i), got_last[i], (i == 7));
        end
    endtask

    task automatic expect_no_rsp(input string tag);
        int seen = 0;
        repeat (14) begin
            if (rsp_tvalid) seen++;
            tick();
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        req_t r, r_first;
        int conn_before, close_before;
        core_rst = 1; Req_Listen = 0; Req_Close = 0; state_ready = 0; rsp_tready = 1;
        handshake_tdata = '0; handshake_tkeep = '0; handshake_tvalid = 0; handshake_tlast = 0;
        Local_ISN = $urandom; Local_SockID = $urandom; MSSize = 32'd1400; FlightFlagSize = 32'd8192;
        m_state = 0; m_drop = 0; m_sid = '0; m_mss = '0; m_flow = '0;
        repeat (3) tick();
        chk("rst_udt_state", udt_state, 0);
        chk("rst_state_valid", state_valid, 0);
        chk("rst_tready", handshake_tready, 0);
        chk("rst_rsp_tvalid", rsp_tvalid, 0);
        chk("rst_drop", Drop_Count, 0);
        chk("rst_pktsize", Max_PktSize, 0);
        core_rst = 0;
        tick();

        Req_Listen = 1; tick(); Req_Listen = 0; m_state = 1;
        chk("listen_state", udt_state, 1);
        chk("listen_valid", state_valid, 1);
        chk("listen_tready", handshake_tready, 1);

        r = make_req(7); r.ver = 32'd3; load_req(r);
        send_pkt(8, 1, -1); expect_no_rsp("ver3_no_rsp"); m_drop++;
        chk("ver3_drop", Drop_Count, m_drop);
        r = make_req(7); load_req(r);
        send_pkt(5, 1, -1); expect_no_rsp("short_no_rsp"); m_drop++;
        chk("short_drop", Drop_Count, m_drop);
        chk("short_state", udt_state, 1);
        chk("short_tready", handshake_tready, 1);

        // First connect with state_ready held low since LISTENING
        conn_before = n_conn;
        r_first = make_req(7); load_req(r_first);
        send_pkt(8, 1, -1);
        m_accept(r_first);
        collect_rsp(0, -1);
        check_rsp("conn");
        chk("conn_tlast_cycle", tlast_cyc, last_cyc + 9);
        chk("conn_res_connect", Res_Connect, 1);
        chk("conn_udt_state", udt_state, 2);
        chk("conn_valid_held", state_valid, 1);
        chk("conn_pktsize", Max_PktSize, 32'd1372);
        chk("conn_payload", Max_PayloadSize, 32'd1356);
        chk("conn_flow", FlowWindowSize, 32'd8192);
        chk("conn_peer_isn", PeerISN, 32'h1000);
        chk("conn_peer_sid", PeerSockID, 32'd7);
        state_ready = 1; tick();
        chk("conn_valid_clear", state_valid, 0);
        chk("conn_pulse_count", n_conn - conn_before, 1);

        // Retransmit in CONNECTED with a stalling consumer
        conn_before = n_conn;
        load_req(r_first); send_pkt(8, 1, -1);
        m_accept(r_first);
        collect_rsp(1, -1);
        check_rsp("retx");
        tick();
        chk("retx_no_connect", n_conn - conn_before, 0);
        chk("retx_peer_isn", PeerISN, 32'h1000);

        r = make_req(9); load_req(r);
        send_pkt(8, 1, -1); expect_no_rsp("sid9_no_rsp"); m_drop++;
        chk("sid9_drop", Drop_Count, m_drop);

        for (int k = 0; k < 12; k++) begin
            r = make_req(($urandom_range(0, 3) == 0) ? 32'd9 : 32'd7);
            if ($urandom_range(0, 4) == 0) r.ver = 32'd3;
            if ($urandom_range(0, 4) == 0) r.rtype = $urandom_range(2, 5);
            if ($urandom_range(0, 4) == 0) r.w0 = 32'h8001_0000;
            r.mss = $urandom_range(60, 2000); r.flight = $urandom; r.isn = $urandom;
            load_req(r);
            send_pkt(8, 1, -1);
            if (m_accepts(r)) begin
                m_accept(r);
                collect_rsp(2, -1);
                check_rsp($sformatf("rand%0d", k));
            end else begin
                expect_no_rsp($sformatf("rand%0d_no_rsp", k));
                m_drop++;
                chk($sformatf("rand%0d_drop", k), Drop_Count, m_drop);
            end
        end
        chk("rand_state", udt_state, 2);

        // Close request during the response: packet completes first
        close_before = n_close;
        r = make_req(7); load_req(r);
        send_pkt(8, 1, -1);
        m_accept(r);
        collect_rsp(0, 3);
        check_rsp("close");
        chk("close_res_close", Res_Close, 1);
        chk("close_udt_state", udt_state, 0);
        chk("close_tready", handshake_tready, 0);
        m_state = 0;
        tick();
        chk("close_pulse_count", n_close - close_before, 1);

        // Bad tkeep mid-packet goes through the drain path
        Req_Listen = 1; tick(); Req_Listen = 0; m_state = 1;
        r = make_req(7); load_req(r);
        send_pkt(8, 1, 2); expect_no_rsp("keep_no_rsp"); m_drop++;
        chk("keep_drop", Drop_Count, m_drop);
        chk("keep_state", udt_state, 1);

        // Reset in the middle of a request
        r = make_req(7); load_req(r);
        send_pkt(3, 0, -1);
        core_rst = 1; tick(); core_rst = 0;
        chk("mrst_udt_state", udt_state, 0);
        chk("mrst_valid", state_valid, 0);
        chk("mrst_tready", handshake_tready, 0);
        chk("mrst_rsp_tvalid", rsp_tvalid, 0);
        chk("mrst_drop", Drop_Count, 0);
        chk("mrst_peer_isn", PeerISN, 0);
        chk("mrst_peer_sid", PeerSockID, 0);
        chk("mrst_flow", FlowWindowSize, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/udt_server_handshake.md
# udt_server_handshake

Server-side (responder) UDT connection manager: waits for a peer's regular-connect handshake control packet and validates it. It negotiates MSS and flight-flag size, then transmits the handshake response (request type −1). It sits beside the client-side initiator on the core clock domain and is its counterpart at the listening end. It exports the negotiated connection parameters to the data path.

## Interface
No parameters.
- core_clk  in  1  core clock
- core_rst  in  1  synchronous, active-high reset
- Req_Listen  in  1  enter listening (honoured only in CLOSED)
- Req_Close  in  1  close request
- Res_Connect  out  1  1-cycle pulse: first response fully sent, connection up
- Res_Close  out  1  1-cycle pulse on entering CLOSED via Req_Close
- Local_ISN, Local_SockID, MSSize, FlightFlagSize  in  32 each  local initial seq no, socket ID, max segment size, max flow window
- handshake_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  64/8/1/1/1  incoming control packets
- rsp_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  64/8/1/1/1  outgoing handshake response
- udt_state  out  32  0 CLOSED, 1 LISTENING, 2 CONNECTED
- state_valid  out  1; state_ready  in  1  state-change handshake
- PeerISN, PeerSockID  out  32  from accepted request
- Max_PktSize, Max_PayloadSize, FlowWindowSize  out  32  negotiated values
- Drop_Count  out  16  rejected packets, saturating

## Operation
- Byte order big-endian: byte 0 in tdata[63:56]. Each beat carries two 32-bit words, high word first.
- Packet = 8 beats:
  - b0: word0, word1
  - b1: timestamp, dest ID
  - b2: version, socket type
  - b3: ISN, MSS
  - b4: flight flag, req type
  - b5: socket ID, cookie
  - b6–b7: peer IP
- FSM states: CLOSED, LISTEN, RECV, CHECK, SEND, CONNECTED, DISCARD.
- CLOSED → LISTEN on Req_Listen.
- LISTEN/CONNECTED → RECV on the first accepted beat. RECV stores beats 0–7 in registers.
- Any of the following → DISCARD, which consumes beats until tlast, then Drop_Count+1 and return to the previous stable state:
  - tkeep≠8'hFF
  - tlast on a beat other than 7
  - no tlast on beat 7
- CHECK takes one cycle. Acceptance requires all of:
  - word0[31]=1 and word0[30:16]=0
  - version=4
  - req type=1
  - peer MSS ≥ 76
  - CONNECTED only: socket ID = PeerSockID; this is a retransmitted request.
- If any check fails: Drop_Count+1 and return to the stable state.
- On pass (LISTEN only), latch:
  - PeerISN, PeerSockID
  - mss = min(peer MSS, MSSize); Max_PktSize = mss−28; Max_PayloadSize = mss−44
  - FlowWindowSize = min(peer flight, FlightFlagSize)
- On pass in CONNECTED: the latched values are left untouched.
- Comparisons are unsigned 32-bit.
- Response beats:
  - b0: 0x80000000, 0
  - b1: rx timestamp, PeerSockID
  - b2: 4, rx socket type
  - b3: Local_ISN, mss
  - b4: FlowWindowSize, 0xFFFFFFFF
  - b5: Local_SockID, rx cookie
  - b6–b7: rx peer IP echoed
- rsp_tkeep = 8'hFF on every beat; rsp_tlast on beat 7.
- After the last beat is accepted, SEND → CONNECTED.
- Res_Connect pulses only on the LISTEN → CONNECTED transition, not on retransmits.
- Req_Close from LISTEN or CONNECTED: go to CLOSED and pulse Res_Close.
  - From RECV, DISCARD or SEND: the request is latched, the current packet is completed (drained, or all 8 beats sent), then CLOSED and pulse Res_Close.
  - From CLOSED: pulse Res_Close only.
  - Req_Close wins over a simultaneous Req_Listen.
- State reporting:
  - Each udt_state change asserts state_valid.
  - state_valid is held until state_ready.
  - A further change while pending updates udt_state and keeps valid high, so only the latest state is delivered.

## Timing
- Reset values:
  - all outputs 0
  - udt_state 0 (CLOSED)
  - state_valid 0
  - handshake_tready 0
  - rsp_tvalid 0
  - FSM in CLOSED
- Reset mid-packet aborts the packet immediately; rsp_tvalid drops at that edge.
- handshake_tready = 1 in LISTEN, RECV, CONNECTED and DISCARD; 0 in CLOSED, CHECK and SEND.
- Latency:
  - Request tlast accepted at cycle N.
  - CHECK at N+1.
  - rsp_tvalid beat 0 at N+2.
  - With rsp_tready held at 1, rsp_tlast at N+9.
  - Res_Connect at N+10 together with the udt_state update.
- Once asserted, rsp_tvalid and rsp_tdata stay stable until rsp_tready; no bubbles within a packet while SEND holds.

## Test plan
- Req_Listen, then a valid request (ISN 0x1000, MSS 1500, flight 25600, sockID 7), local MSSize 1400, FlightFlagSize 8192, rsp_tready=1 -> response b3 = Local_ISN/1400 and b4 = 8192/0xFFFFFFFF; Max_PktSize 1372; Max_PayloadSize 1356; rsp_tlast at N+9; Res_Connect at N+10; udt_state 2.
- Request with version=3, then a 5-beat packet with early tlast -> no response; Drop_Count=2; state stays LISTENING; tready keeps accepting.
- In CONNECTED: resend the same request with sockID 7 -> identical response, no Res_Connect. Request with sockID 9 -> dropped.
- rsp_tready toggled 1-0-1 each cycle -> all 8 beats delivered intact; rsp_tdata stable while stalled.
- Req_Close pulsed at SEND beat 3 -> all 8 beats still sent, then CLOSED, Res_Close pulse, udt_state 0.
- state_ready held 0 across LISTENING → CONNECTED -> state_valid stays 1 and udt_state reads 2 when finally accepted. core_rst asserted mid-RECV -> all outputs at reset values after one edge.
